// File: rtl/win_3x3_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window.
// Stride 2 support is compiled in only when WIN_STRIDE2_EN is defined.
module win_3x3_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_WIDTH  = 256,
   parameter int DIM_W      = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_start,
   input  logic [DIM_W-1:0]        cfg_width,
   input  logic [DIM_W-1:0]        cfg_height,
   input  logic                    cfg_stride,
   output logic                    cfg_err,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [9*DATA_WIDTH-1:0] out_win,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);
   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [DIM_W:0] MAXW = MAX_WIDTH[DIM_W:0];

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                     r_state, w_state_nxt;
   logic [DIM_W-1:0]           r_width, r_height, r_last_row, r_last_col, r_row, r_col;
   logic [DIM_W-1:0]           w_last_row, w_last_col;
   logic [8:0][DATA_WIDTH-1:0] r_win, w_win_nxt, r_out_win;
   logic                       r_out_valid, r_out_last, r_cfg_err, r_done;
   logic [DATA_WIDTH-1:0]      r_lb0 [MAX_WIDTH];
   logic [DATA_WIDTH-1:0]      r_lb1 [MAX_WIDTH];
   logic                       w_cfg_ok, w_cfg_go, w_accept, w_row_end, w_frame_end;
   logic                       w_emit, w_grid, w_cfg_s2, w_drain_ok;
   logic [AW-1:0]              w_addr;

`ifdef WIN_STRIDE2_EN
   logic r_stride;
   assign w_cfg_s2 = cfg_stride;
   // (n-2)%2==0 reduces to n being even
   assign w_grid   = !r_stride || (!r_row[0] && !r_col[0]);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_stride <= 1'b0;
      else if (w_cfg_go) r_stride <= cfg_stride;
   end
`else
   logic w_unused_stride;
   assign w_unused_stride = cfg_stride;
   assign w_cfg_s2        = 1'b0;
   assign w_grid          = 1'b1;
`endif

   assign w_cfg_ok = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3)) &&
                     ({1'b0, cfg_width} <= MAXW);
   assign w_cfg_go = (r_state == S_IDLE) && cfg_start && w_cfg_ok;

   // 2+2*((N-3)/2) is N-1 when N is odd and N-2 when N is even
   assign w_last_row = cfg_height - DIM_W'(1) - {{(DIM_W-1){1'b0}}, w_cfg_s2 & ~cfg_height[0]};
   assign w_last_col = cfg_width  - DIM_W'(1) - {{(DIM_W-1){1'b0}}, w_cfg_s2 & ~cfg_width[0]};

   assign w_accept    = in_valid && in_ready;
   assign w_row_end   = (r_col == r_width - DIM_W'(1));
   assign w_frame_end = w_row_end && (r_row == r_height - DIM_W'(1));
   assign w_emit      = w_accept && (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2)) && w_grid;
   assign w_drain_ok  = (r_state == S_DRAIN) && (!r_out_valid || out_ready);
   assign w_addr      = r_col[AW-1:0];

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         w_win_nxt[3*r]   = r_win[3*r+1];
         w_win_nxt[3*r+1] = r_win[3*r+2];
      end
      w_win_nxt[2] = r_lb1[w_addr];
      w_win_nxt[5] = r_lb0[w_addr];
      w_win_nxt[8] = in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_cfg_go)                w_state_nxt = S_RUN;
         S_RUN:   if (w_accept && w_frame_end) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_drain_ok)              w_state_nxt = S_IDLE;
         default:                              w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
      busy     = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_width     <= '0;
         r_height    <= '0;
         r_last_row  <= '0;
         r_last_col  <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_win       <= '0;
         r_out_win   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_cfg_err <= (r_state == S_IDLE) && cfg_start && !w_cfg_ok;
         r_done    <= w_drain_ok;
         if (w_cfg_go) begin
            r_width    <= cfg_width;
            r_height   <= cfg_height;
            r_last_row <= w_last_row;
            r_last_col <= w_last_col;
            r_row      <= '0;
            r_col      <= '0;
         end
         if (w_accept) begin
            r_win <= w_win_nxt;
            if (w_row_end) begin
               r_col <= '0;
               r_row <= r_row + DIM_W'(1);
            end else begin
               r_col <= r_col + DIM_W'(1);
            end
         end
         // a reload can only happen when the held window is leaving, so nothing is lost
         if (w_emit) begin
            r_out_win   <= w_win_nxt;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_row == r_last_row) && (r_col == r_last_col);
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb1[w_addr] <= r_lb0[w_addr];
         r_lb0[w_addr] <= in_data;
      end
   end

   assign out_win   = r_out_win;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign cfg_err   = r_cfg_err;
   assign done      = r_done;
endmodule

// File: tb/tb_win_3x3_gen.sv
// Randomized bench for win_3x3_gen: windows are derived from whole-frame pixel arrays
// and compared on every output handshake, plus literal anchor windows.
`timescale 1ns/1ps
module tb_win_3x3_gen;
   localparam int DW = 16, MAXW = 256, DIM_W = 9;
`ifdef WIN_STRIDE2_EN
   localparam bit S2_EN = 1'b1;
`else
   localparam bit S2_EN = 1'b0;
`endif

   logic             clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, cfg_stride = 1'b0;
   logic             in_valid = 1'b0, out_ready = 1'b0;
   logic [DIM_W-1:0] cfg_width = '0, cfg_height = '0;
   logic [DW-1:0]    in_data = '0;
   logic             cfg_err, in_ready, out_valid, out_last, busy, done;
   logic [9*DW-1:0]  out_win;

   win_3x3_gen #(.DATA_WIDTH(DW), .MAX_WIDTH(MAXW), .DIM_W(DIM_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_width(cfg_width),
      .cfg_height(cfg_height), .cfg_stride(cfg_stride), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
      .out_last(out_last), .busy(busy), .done(done));

   always #5 clk = ~clk;

   typedef struct { logic [9*DW-1:0] win; logic last; } win_t;
   win_t            exp_q[$];
   win_t            cur_e;
   logic [DW-1:0]   pix [0:1023];
   int              checks = 0, failures = 0;
   int              done_cnt = 0, win_idx = 0, stall_seen = 0, acc_cnt = 0;
   int              cur_w = 4, cur_s = 1;
   int              rdy_mode = 0, stall_left = 0;
   bit              stall_armed = 1'b0, prev_stall = 1'b0, pend_emit = 1'b0;
   logic [9*DW-1:0] first_win, last_win, prev_win, tmpw;

   task automatic chk_b(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [9*DW-1:0] mkwin(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
      logic [9*DW-1:0] w;
      w[0*DW +: DW] = e0[DW-1:0]; w[1*DW +: DW] = e1[DW-1:0]; w[2*DW +: DW] = e2[DW-1:0];
      w[3*DW +: DW] = e3[DW-1:0]; w[4*DW +: DW] = e4[DW-1:0]; w[5*DW +: DW] = e5[DW-1:0];
      w[6*DW +: DW] = e6[DW-1:0]; w[7*DW +: DW] = e7[DW-1:0]; w[8*DW +: DW] = e8[DW-1:0];
      return w;
   endfunction

   // Pixel n is a window's bottom-right corner when it sits on the stride grid.
   function automatic bit is_br(input int n);
      int r = n / cur_w;
      int c = n % cur_w;
      return (r >= 2) && (c >= 2) && ((r - 2) % cur_s == 0) && ((c - 2) % cur_s == 0);
   endfunction

   // Expected windows enumerated by top-left corner in raster order.
   task automatic build(input int w, input int h, input int st, input bit idx);
      int s = (S2_EN && st != 0) ? 2 : 1;
      exp_q.delete();
      for (int p = 0; p < w*h; p++) pix[p] = idx ? DW'(p) : DW'($urandom);
      for (int i = 0; i + 2 < h; i += s)
         for (int j = 0; j + 2 < w; j += s) begin
            win_t e;
            for (int k = 0; k < 9; k++) e.win[k*DW +: DW] = pix[(i + k/3)*w + j + k%3];
            e.last = (i + s + 2 >= h) && (j + s + 2 >= w);
            exp_q.push_back(e);
         end
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 2 && stall_armed && out_valid) begin
         stall_left  = 5;
         stall_armed = 1'b0;
      end
      if (stall_left > 0) begin
         out_ready  = 1'b0;
         stall_left = stall_left - 1;
      end else if (rdy_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else                        out_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk_b("rst_flags", |{out_valid, out_last, in_ready, busy, done, cfg_err}, 1'b0);
         chk_w("rst_win", out_win, '0);
         prev_stall = 1'b0;
         pend_emit  = 1'b0;
      end else begin
         if (!busy) chk_b("idle_in_ready", in_ready, 1'b0);
         if (busy)  chk_b("busy_cfg_err", cfg_err, 1'b0);
         if (pend_emit) chk_b("emit_latency", out_valid, 1'b1);
         if (prev_stall) begin
            chk_b("stall_valid", out_valid, 1'b1);
            chk_w("stall_win", out_win, prev_win);
         end
         if (out_valid && !out_ready) begin
            chk_b("stall_in_ready", in_ready, 1'b0);
            stall_seen++;
         end
         if (out_valid && out_ready) begin
            chk_b("win_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               cur_e = exp_q.pop_front();
               chk_w("win", out_win, cur_e.win);
               chk_b("last", out_last, cur_e.last);
               if (win_idx == 0) first_win = out_win;
               if (out_last) last_win = out_win;
               win_idx++;
            end
         end
         if (done) done_cnt++;
         pend_emit = in_valid && in_ready && is_br(acc_cnt);
         if (in_valid && in_ready) acc_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_win   = out_win;
      end
   end

   task automatic do_cfg(input int w, input int h, input int st);
      cur_w   = w;
      cur_s   = (S2_EN && st != 0) ? 2 : 1;
      acc_cnt = 0;
      cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_stride = 1'(st); cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      chk_b("cfg_busy", busy, 1'b1);
   endtask

   task automatic feed(input int n, input bit rnd, input bit poke_cfg);
      int p = 0;
      int guard = 0;
      while (p < n) begin
         in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data  = in_valid ? pix[p] : DW'($urandom);
         if (poke_cfg) begin
            cfg_start  = ($urandom_range(0, 15) == 0);
            cfg_width  = DIM_W'(2);
            cfg_height = DIM_W'($urandom);
            cfg_stride = 1'($urandom);
         end
         @(negedge clk);
         if (in_valid && in_ready) p++;
         @(posedge clk); #1;
         guard++;
         if (guard > 5000) begin
            chk_i("feed_timeout", p, n);
            break;
         end
      end
      in_valid  = 1'b0;
      cfg_start = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (done_cnt == 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      repeat (3) @(negedge clk);
      chk_i("done_once", done_cnt, 1);
      chk_i("queue_empty", exp_q.size(), 0);
      chk_b("busy_end", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input int w, input int h, input int st, input bit idx,
                            input bit rnd, input int rmode);
      build(w, h, st, idx);
      done_cnt  = 0;
      win_idx   = 0;
      first_win = '0;
      last_win  = '0;
      rdy_mode  = rmode;
      stall_armed = (rmode == 2);
      do_cfg(w, h, st);
      feed(w*h, rnd, rnd);
      wait_done();
   endtask

   task automatic cfg_reject(input int w, input int h);
      cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_stride = 1'b0;
      cfg_start = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk_b("rej_err_early", cfg_err, 1'b0);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);
      chk_b("rej_err_pulse", cfg_err, 1'b1);
      chk_b("rej_busy", busy, 1'b0);
      chk_b("rej_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_b("rej_err_clear", cfg_err, 1'b0);
      chk_b("rej_busy2", busy, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      build(4, 4, 0, 1);
      chk_i("model_cnt_4x4", exp_q.size(), 4);
      tmpw = exp_q[0].win;
      chk_w("model_first_4x4", tmpw, mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10));
      tmpw = exp_q[3].win;
      chk_w("model_last_4x4", tmpw, mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15));
      chk_b("model_lastflag_4x4", exp_q[3].last, 1'b1);

      run_frame(4, 4, 0, 1, 1'b0, 0);
      chk_i("dut_nwin_4x4", win_idx, 4);
      chk_w("dut_first_4x4", first_win, mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk_w("dut_last_4x4", last_win, mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15));

      stall_seen = 0;
      run_frame(4, 4, 0, 1, 1'b0, 2);
      chk_i("stall_cycles", stall_seen, 5);
      chk_i("stall_nwin", win_idx, 4);
      chk_w("stall_last", last_win, mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15));

      cfg_reject(2, 4);
      cfg_reject(MAXW + 1, 4);
      cfg_reject(5, 2);

      run_frame(MAXW, 3, 0, 0, 1'b0, 0);
      chk_i("maxw_nwin", win_idx, MAXW - 2);

`ifdef WIN_STRIDE2_EN
      build(5, 5, 1, 1);
      chk_i("model_cnt_5x5s2", exp_q.size(), 4);
      tmpw = exp_q[1].win;
      chk_i("model_tl1_5x5s2", int'(tmpw[DW-1:0]), 2);
      tmpw = exp_q[2].win;
      chk_i("model_tl2_5x5s2", int'(tmpw[DW-1:0]), 10);
      run_frame(5, 5, 1, 1, 1'b0, 0);
      chk_i("dut_nwin_5x5s2", win_idx, 4);
      chk_w("dut_first_5x5s2", first_win, mkwin(0, 1, 2, 5, 6, 7, 10, 11, 12));
      chk_i("dut_last_tl_5x5s2", int'(last_win[DW-1:0]), 12);
      run_frame(6, 4, 1, 1, 1'b0, 0);
      chk_i("dut_nwin_6x4s2", win_idx, 2);
      chk_i("dut_last_tl_6x4s2", int'(last_win[DW-1:0]), 2);
`endif

      build(4, 4, 0, 1);
      done_cnt = 0;
      rdy_mode = 0;
      do_cfg(4, 4, 0);
      feed(7, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_b("post_reset_busy", busy, 1'b0);
      chk_i("post_reset_done", done_cnt, 0);
      run_frame(3, 3, 0, 1, 1'b0, 0);
      chk_i("rst_nwin_3x3", win_idx, 1);
      chk_w("rst_first_3x3", first_win, mkwin(0, 1, 2, 3, 4, 5, 6, 7, 8));
      chk_w("rst_last_3x3", last_win, mkwin(0, 1, 2, 3, 4, 5, 6, 7, 8));

      for (int t = 0; t < 12; t++)
         run_frame($urandom_range(3, 12), $urandom_range(3, 8), $urandom_range(0, 1),
                   1'b0, 1'b1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
